// File: rtl/serial_sub_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : serial_sub_pkg                                     |
// | Description : Shared state encoding and default width for the    |
// |               bit-serial subtractor.                             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/full_sub_cell.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : full_sub_cell                                      |
// | Description : One-bit combinational full subtractor computing    |
// |               x - y - bi, returning difference d and borrow bo.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module full_sub_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   // Difference bit and borrow-out of a single-bit subtraction
   always_comb begin
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~(x ^ y) & bi);
   end

endmodule : full_sub_cell
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : serial_subtractor                                  |
// | Description : Bit-serial a - b - bin, LSB first, one bit per     |
// |               clock through a single full-subtractor cell, with  |
// |               valid/ready handshakes on operands and result.     |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_sr;
   logic [CW-1:0]    count;
   logic             borrow;
   logic             bout_q;
   logic             ovf_q;
   logic             cell_d;
   logic             cell_bo;
   logic             accept;
   logic             last_bit;

   assign accept   = (state == IDLE) && start_valid;
   assign last_bit = (state == SHIFT) && (count == LAST);

   assign diff = diff_sr;
   assign bout = bout_q;
   assign ovf  = ovf_q;

   full_sub_cell u_cell (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .bi (borrow),
      .d  (cell_d),
      .bo (cell_bo)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake/status decode
   always_comb begin
      state_nxt   = state;
      start_ready = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (count == LAST) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand shifting, result assembly and borrow chain; the borrow into
   // the MSB is the registered borrow on the last bit, so overflow is its
   // XOR with the cell's borrow-out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         diff_sr <= '0;
         count   <= '0;
         borrow  <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (accept) begin
         a_sr   <= a;
         b_sr   <= b;
         borrow <= bin;
         count  <= '0;
      end else if (state == SHIFT) begin
         a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
         diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
         borrow  <= cell_bo;
         count   <= count + CW'(1);
         if (last_bit) begin
            bout_q <= cell_bo;
            ovf_q  <= borrow ^ cell_bo;
         end
      end
   end

endmodule : serial_subtractor
`default_nettype wire
